// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and defaults for the input debouncer and the
//               downstream dual-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

   // Default configuration of the debouncer
   localparam int DB_SYNC_STAGES_DEF   = 2;
   localparam int DB_STABLE_CYCLES_DEF = 20;

   // Debouncer FSM encoding: bit 1 is the accepted level, so the output
   // decode is a single flop bit
   typedef enum logic [1:0] {
      ZERO  = 2'b00,
      WAIT1 = 2'b01,
      ONE   = 2'b11,
      WAIT0 = 2'b10
   } db_state_t;

   // Dual-edge detector state encodings (consumed by the next stage)
   typedef enum logic [1:0] {
      ED_IDLE = 2'b00,
      ED_RISE = 2'b01,
      ED_FALL = 2'b10
   } ed_state_t;

   // Accepted level carried by a debouncer state
   function automatic logic db_level(input db_state_t st);
      return st[1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : Plain flop chain that brings an asynchronous level into the
//               clk domain. No logic between stages.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_sync;

   // Shift the raw input through the chain; every stage clears on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d};
      end
   end

   assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Synchronises a bouncy asynchronous input and only accepts a
//               new level once it has held for STABLE_CYCLES clocks.
//               Optional macro DEBOUNCE_GLITCH_CNT_EN adds a saturating
//               8-bit count of rejected excursions (glitch_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = DB_SYNC_STAGES_DEF,
   parameter int STABLE_CYCLES = DB_STABLE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sig_in,
   output logic       sig_out,
   output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   localparam int               CNT_W  = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(STABLE_CYCLES - 1);

   logic             w_sync;
   db_state_t        r_state;
   db_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (sig_in),
      .q   (w_sync)
   );

   // State and stability counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ZERO;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state and counter logic; a fresh candidate always reloads the
   // full count, and the decrement is guarded so the counter never wraps
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ZERO: begin
            if (w_sync) begin
               w_state_nxt = WAIT1;
               w_cnt_nxt   = c_LOAD;
            end
         end
         WAIT1: begin
            if (!w_sync) begin
               w_state_nxt = ZERO;
            end else if (r_cnt == '0) begin
               w_state_nxt = ONE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ONE: begin
            if (!w_sync) begin
               w_state_nxt = WAIT0;
               w_cnt_nxt   = c_LOAD;
            end
         end
         WAIT0: begin
            if (w_sync) begin
               w_state_nxt = ONE;
            end else if (r_cnt == '0) begin
               w_state_nxt = ZERO;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = ZERO;
         end
      endcase
   end

   // Moore output decode from the registered state only
   always_comb begin
      sig_out = db_level(r_state);
      busy    = (r_state == WAIT1) || (r_state == WAIT0);
   end

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic       w_glitch;
   logic [7:0] r_glitch_cnt;

   // A glitch is a WAIT state falling back to the level it left
   always_comb begin
      w_glitch = ((r_state == WAIT1) && !w_sync) ||
                 ((r_state == WAIT0) &&  w_sync);
   end

   // Saturating count of rejected excursions, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_glitch_cnt <= '0;
      end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
         r_glitch_cnt <= r_glitch_cnt + 8'd1;
      end
   end

   assign glitch_cnt = r_glitch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debouncer
// Description : Directed self-checking bench for input_debouncer; one
//               instance with defaults and one with STABLE_CYCLES=1.
//               Glitch-count checks are active with DEBOUNCE_GLITCH_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

   logic clk = 1'b0;
   logic rst;
   logic sig_in;
   logic sig_in1;
   logic sig_out;
   logic busy;
   logic sig_out1;
   logic busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_cnt;
   logic [7:0] glitch_cnt1;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   input_debouncer u_dut (
      .clk     (clk),
      .rst     (rst),
      .sig_in  (sig_in),
      .sig_out (sig_out),
      .busy    (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt (glitch_cnt)
`endif
   );

   input_debouncer #(
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (1)
   ) u_dut1 (
      .clk     (clk),
      .rst     (rst),
      .sig_in  (sig_in1),
      .sig_out (sig_out1),
      .busy    (busy1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt (glitch_cnt1)
`endif
   );

   // One active edge, then settle 1 ns so outputs are sampled off the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic any_high;
      logic busy_seen;

      // ---------------- reset ----------------
      rst     = 1'b1;
      sig_in  = 1'b0;
      sig_in1 = 1'b0;
      repeat (3) step();
      check("rst_sig_out", 8'(sig_out), 8'd0);
      check("rst_busy",    8'(busy),    8'd0);
      check("rst_sig_out1", 8'(sig_out1), 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("rst_glitch", glitch_cnt, 8'd0);
`endif
      #4 rst = 1'b0;

      // ---------------- idle 100 cycles ----------------
      any_high = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         any_high = any_high | sig_out | busy | sig_out1 | busy1;
      end
      check("idle_quiet", 8'(any_high), 8'd0);

      // ---------------- clean rise: step n is edge k+n-1 ----------------
      sig_in = 1'b1;
      step(); step();
      check("rise_busy_pre", 8'(busy), 8'd0);
      step();
      check("rise_busy_on", 8'(busy), 8'd1);
      check("rise_out_wait", 8'(sig_out), 8'd0);
      repeat (19) step();
      check("rise_out_k21", 8'(sig_out), 8'd0);
      check("rise_busy_k21", 8'(busy), 8'd1);
      step();
      check("rise_out_k22", 8'(sig_out), 8'd1);
      check("rise_busy_k22", 8'(busy), 8'd0);
      repeat (5) step();
      check("rise_hold", 8'(sig_out), 8'd1);

      // ---------------- bounce rejection ----------------
      any_high  = 1'b1;
      busy_seen = 1'b0;
      sig_in = 1'b0;
      for (int i = 0; i < 5; i++) begin step(); any_high &= sig_out; busy_seen |= busy; end
      check("bounce_busy_low5", 8'(busy_seen), 8'd1);
      sig_in = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); any_high &= sig_out; end
      check("bounce_idle_hi3", 8'(busy), 8'd0);
      busy_seen = 1'b0;
      sig_in = 1'b0;
      for (int i = 0; i < 7; i++) begin step(); any_high &= sig_out; busy_seen |= busy; end
      check("bounce_busy_low7", 8'(busy_seen), 8'd1);
      sig_in = 1'b1;
      for (int i = 0; i < 12; i++) begin step(); any_high &= sig_out; end
      check("bounce_out_held", 8'(any_high), 8'd1);
      check("bounce_busy_end", 8'(busy), 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("bounce_glitch", glitch_cnt, 8'd2);
`endif

      // ---------------- clean fall ----------------
      sig_in = 1'b0;
      repeat (22) step();
      check("fall_out_k21", 8'(sig_out), 8'd1);
      step();
      check("fall_out_k22", 8'(sig_out), 8'd0);
      check("fall_busy_k22", 8'(busy), 8'd0);

      // ---------------- reset mid-qualification ----------------
      sig_in = 1'b1;
      repeat (15) step();
      check("midq_busy", 8'(busy), 8'd1);
      check("midq_cnt", 8'(u_dut.r_cnt), 8'd7);
      rst = 1'b1;
      #1;
      check("midq_rst_out", 8'(sig_out), 8'd0);
      check("midq_rst_busy", 8'(busy), 8'd0);
      repeat (3) step();
      #3 rst = 1'b0;
      repeat (22) step();
      check("midq_out_k21", 8'(sig_out), 8'd0);
      step();
      check("midq_out_k22", 8'(sig_out), 8'd1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("midq_glitch", glitch_cnt, 8'd0);
`endif

      // ---------------- STABLE_CYCLES=1: 1-cycle pulse rejected ----------------
      any_high  = 1'b0;
      busy_seen = 1'b0;
      sig_in1 = 1'b1;
      step();
      sig_in1 = 1'b0;
      for (int i = 0; i < 6; i++) begin step(); any_high |= sig_out1; busy_seen |= busy1; end
      check("sc1_pulse1_out", 8'(any_high), 8'd0);
      check("sc1_pulse1_busy", 8'(busy_seen), 8'd1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("sc1_glitch1", glitch_cnt1, 8'd1);
`endif

      // ---------------- STABLE_CYCLES=1: 2-cycle pulse accepted ----------------
      sig_in1 = 1'b1;
      step(); step();
      sig_in1 = 1'b0;
      step();
      check("sc1_pulse2_k2", 8'(sig_out1), 8'd0);
      step();
      check("sc1_pulse2_k3", 8'(sig_out1), 8'd1);
      step();
      check("sc1_pulse2_k4", 8'(sig_out1), 8'd1);
      step();
      check("sc1_pulse2_k5", 8'(sig_out1), 8'd0);
      repeat (3) step();

`ifdef DEBOUNCE_GLITCH_CNT_EN
      // ---------------- glitch counter saturation ----------------
      for (int i = 0; i < 253; i++) begin
         sig_in1 = 1'b1; step();
         sig_in1 = 1'b0; step();
      end
      repeat (4) step();
      check("sat_254", glitch_cnt1, 8'd254);
      for (int i = 0; i < 47; i++) begin
         sig_in1 = 1'b1; step();
         sig_in1 = 1'b0; step();
      end
      repeat (4) step();
      check("sat_255", glitch_cnt1, 8'd255);
      check("sat_out", 8'(sig_out1), 8'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
